gate_bist: RTL
==============

Name: gate_bist

Overview:
Hardware counterpart to the gate testbenches: a self-checking exhaustive stimulus and response block for N-input reduction gates.
- Drives all 2^N input vectors into a combinational gate DUT, one vector per cycle.
- Compares the DUT output against an internally computed expected value.
- Compacts the response stream into a signature.
- Reports pass/fail, error count and first failing vector.
- Sits beside a gate instance at the top level for on-chip self-test.

Parameters:
N, 2, DUT input width; 1..16.
SIG_W, 16, signature LFSR width; fixed taps below require 16.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle request to begin a run.
op_sel  input  2  expected function: 00 OR, 01 AND, 10 XOR, 11 NOR; latched at start.
dut_out  input  1  DUT output; combinational response to vec_out.
vec_out  output  N  registered stimulus vector to DUT.
vec_valid  output  1  high while vec_out carries a live test vector.
busy  output  1  high in RUN.
done  output  1  high in DONE.
pass  output  1  valid when done=1; 1 iff err_cnt==0.
err_cnt  output  N+1  number of mismatching vectors in the last run.
first_fail  output  N  vector of first mismatch; 0 if none.
signature  output  SIG_W  response compaction register.

Behaviour:
Reset:
- Async assert: state=IDLE; every output = 0.
- Deassert is sampled at the next rising edge.

States: IDLE, RUN, DONE.

IDLE:
- start=1 at an edge -> RUN. At the same edge: op latched; vec_out=0; vec_valid=1; busy=1; err_cnt, first_fail and signature cleared to 0.

RUN, at every edge:
- Compare: expected = f_op(vec_out), where f is OR, AND, XOR or NOR reduction of vec_out.
- Mismatch when dut_out != expected:
  - err_cnt increments.
  - If err_cnt was 0 before this edge, first_fail <= vec_out.
- Signature update, every RUN edge regardless of mismatch:
  - fb = sig[15]^sig[13]^sig[12]^sig[10]^dut_out
  - sig <= {sig[14:0], fb}
- Advance: if vec_out != 2^N-1, vec_out <= vec_out+1. Otherwise -> DONE with vec_valid=0, busy=0, done=1, pass=(final err_cnt==0).
- Run length: exactly 2^N compare edges. Start sampled at edge k gives done=1 after edge k+2^N.
- err_cnt cannot overflow; its maximum is 2^N.

DONE:
- All results hold; vec_out holds its last value.
- start=1 -> RUN, identical to the IDLE transition (restart clears results); done and pass drop at that same edge.

Other rules:
- start while in RUN is ignored; op_sel changes during RUN are ignored.
- Reset mid-run aborts immediately to IDLE with all outputs 0; no partial result is retained.
- No combinational path from any input to any output.

Test Plan:
1. N=2, op=OR, correct OR DUT, start pulse -> vec_out 0,1,2,3 on consecutive cycles; done after 4 cycles; pass=1, err_cnt=0, first_fail=0, signature=16'h0007.
2. N=2, op=OR, DUT stuck-at-0 -> err_cnt=3, first_fail=2'b01, pass=0, signature=16'h0000.
3. N=2, op=AND, DUT = OR gate -> mismatches at vectors 1 and 2; err_cnt=2, first_fail=2'b01, pass=0.
4. N=3, op=XOR, correct XOR DUT -> 8 vectors; done 8 cycles after start; pass=1. A start pulse at cycle 3 of the run is ignored: same vector sequence and same result.
5. Reset asserted asynchronously at vector 2 of an N=2 run -> all outputs 0 immediately. A fresh start then completes a full 4-vector run with correct results.
6. From DONE with pass=0, start with op=NOR and a correct NOR DUT -> err_cnt and first_fail cleared at the start edge; final pass=1, err_cnt=0.

Source files
------------

// File: rtl/gate_bist.sv
// Exhaustive stimulus/response self-test for an N-input reduction gate.
// Walks every input vector, checks the gate against the selected function and compacts its outputs into an LFSR signature.
module gate_bist #(
  parameter int N     = 2,
  parameter int SIG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op_sel,
  input  logic             dut_out,
  output logic [N-1:0]     vec_out,
  output logic             vec_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N:0]       err_cnt,
  output logic [N-1:0]     first_fail,
  output logic [SIG_W-1:0] signature
);

  // state   | meaning
  // S_IDLE  | waiting for start, outputs cleared by reset
  // S_RUN   | one vector compared per edge
  // S_DONE  | results held until the next start
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [N:0]   ERR_ONE = 1;
  localparam logic [N-1:0] VEC_ONE = 1;

  logic [1:0] state;
  logic [1:0] op;
  logic       expected;
  logic       mismatch;
  logic       fb;

  always_comb begin
    expected = 1'b0;
    case (op)
      2'b00:   expected = |vec_out;
      2'b01:   expected = &vec_out;
      2'b10:   expected = ^vec_out;
      default: expected = ~|vec_out;
    endcase
  end

  assign mismatch = (dut_out != expected);
  assign fb       = signature[15] ^ signature[13] ^ signature[12] ^ signature[10] ^ dut_out;

  // Status flags decode straight from the state register, so no input reaches them combinationally.
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign pass = (state == S_DONE) && (err_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op         <= 2'b00;
      vec_out    <= '0;
      vec_valid  <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
      signature  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RUN;
            op         <= op_sel;
            vec_out    <= '0;
            vec_valid  <= 1'b1;
            err_cnt    <= '0;
            first_fail <= '0;
            signature  <= '0;
          end
        end
        S_RUN: begin
          if (mismatch) begin
            err_cnt <= err_cnt + ERR_ONE;
            if (err_cnt == '0)
              first_fail <= vec_out;
          end
          signature <= {signature[SIG_W-2:0], fb};
          if (&vec_out) begin
            state     <= S_DONE;
            vec_valid <= 1'b0;
          end else begin
            vec_out <= vec_out + VEC_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
